mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte address width.
REQ-002 SHALL have parameter: DATA_W, 32, word width; only 32 is supported.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: req_valid  in  1; req_ready  out  1; req_we  in  1 (1=store, 0=load); req_size  in  2 (00 byte, 01 half, 10 word, 11 treated as word); req_signed  in  1; req_addr  in  ADDR_W; req_wdata  in  DATA_W.
REQ-006 SHALL have ports: rsp_done  out  1; rsp_rdata  out  DATA_W; rsp_err  out  1.
REQ-007 SHALL have ports: ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_we  out  1; ram_re  out  1; ram_rdata  in  DATA_W (combinational word-RAM read).

Function
REQ-008 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-009 SHALL accept a request when req_valid=1 in IDLE, latching addr/size/we/signed/wdata; req_valid outside IDLE is ignored.
REQ-010 SHALL transition on accept: load or sub-word store -> RD; word store -> WR; misaligned (see REQ-018) -> RESP with no RAM access.
REQ-011 SHALL in RD drive ram_re=1, ram_addr={addr[ADDR_W-1:2],2'b00}, capture ram_rdata; load -> RESP, sub-word store -> WR.
REQ-012 SHALL in WR drive ram_we=1 for exactly one cycle, ram_addr word-aligned, ram_wdata = captured word with selected byte lane(s) replaced (read-modify-write); word store writes req_wdata unchanged; then -> RESP.
REQ-013 SHALL in RESP pulse rsp_done=1 for one cycle, then -> IDLE; next request acceptable the following cycle.
REQ-014 SHALL give latency accept-to-rsp_done: load 2 cycles, word store 2, byte/half store 3.
REQ-015 SHALL use little-endian lanes: byte at addr[1:0]*8, half at addr[1]*16.
REQ-016 SHALL return loads in rsp_rdata zero-extended (req_signed=0) or sign-extended (req_signed=1); stores return rsp_rdata=0.
REQ-017 SHALL hold ram_we=0 and ram_re=0 outside WR/RD respectively; ram_we/ram_re decode combinationally from state only.
REQ-018 SHALL define misaligned as half with addr[0]=1 or word with addr[1:0]!=0.
REQ-019 SHALL hold rsp_rdata/rsp_err stable from RESP until next accept.

Reset
REQ-020 SHALL on reset=0 immediately force state IDLE, ram_we=0, ram_re=0, rsp_done=0, rsp_err=0, rsp_rdata=0, ram_addr=0, ram_wdata=0, req_ready=1 after release.
REQ-021 SHALL abandon an in-flight request on reset with no RAM write issued and no rsp_done.

Configuration
REQ-022 SHALL, with MAU_MISALIGN_TRAP_EN defined, send misaligned requests to RESP with rsp_err=1, rsp_rdata=0, no RAM access.
REQ-023 SHALL, without MAU_MISALIGN_TRAP_EN, force offending low address bits to zero, execute normally, and tie rsp_err=0.

Structure
REQ-024 SHALL place size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and state encodings in shared package mau_pkg.
REQ-025 SHALL implement lane merge (store) and extract/extend (load) in combinational sub-module mau_lane_merge.

Verification
REQ-026 SHALL test: RAM word 0x10 = 0x8899AABB, byte load addr 0x11 signed -> rsp_rdata 0xFFFFFFAA at cycle 2.
REQ-027 SHALL test: same word, half store 0x1234 to 0x12 -> single ram_we pulse, word 0x10 = 0x1234AABB, rsp_done at cycle 3.
REQ-028 SHALL test: word store 0xDEADBEEF to 0x04 then word load 0x04 -> 0xDEADBEEF, no RD cycle during store.
REQ-029 SHALL test: half load from 0x03 -> with MAU_MISALIGN_TRAP_EN rsp_err=1, ram_re never 1; without, reads half at 0x02, rsp_err=0.
REQ-030 SHALL test: reset=0 asserted in RD of a byte store to 0x20 -> ram_we never asserted, word 0x20 unchanged, req_ready=1 after release.
REQ-031 SHALL test: req_valid held high during a busy store -> only one request accepted, second accepted cycle after rsp_done.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM state
// encoding and small request-decoding helpers.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } mau_state_e;

  // Size code 2'b11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == SZ_BYTE || sz == SZ_HALF) ? sz : SZ_WORD;
  endfunction

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational little-endian lane logic: merges store data into a word
// (read-modify-write) and extracts/extends load data from a word.
module mau_lane_merge
  import mau_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  bshift;
  logic [4:0]  hshift;
  logic [31:0] byte_src;
  logic [31:0] half_src;

  assign bshift   = {lo_i, 3'b000};
  assign hshift   = {lo_i[1], 4'b0000};
  assign byte_src = rd_word_i >> bshift;
  assign half_src = rd_word_i >> hshift;

  // Replace the addressed lane(s) of the old word with the store data.
  always_comb begin
    st_word_o = wdata_i;
    case (size_i)
      SZ_BYTE: st_word_o = (old_word_i & ~(32'h0000_00FF << bshift)) |
                           ({24'h0, wdata_i[7:0]} << bshift);
      SZ_HALF: st_word_o = (old_word_i & ~(32'h0000_FFFF << hshift)) |
                           ({16'h0, wdata_i[15:0]} << hshift);
      default: st_word_o = wdata_i;
    endcase
  end

  // Pick the addressed lane(s) and zero- or sign-extend to a full word.
  always_comb begin
    ld_data_o = rd_word_i;
    case (size_i)
      SZ_BYTE: ld_data_o = {{24{signed_i & byte_src[7]}}, byte_src[7:0]};
      SZ_HALF: ld_data_o = {{16{signed_i & half_src[15]}}, half_src[15:0]};
      default: ld_data_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide RAM with combinational read.
// Sub-word stores are done as read-modify-write.
// Optional macro MAU_MISALIGN_TRAP_EN: misaligned requests answer with
// rsp_err=1 and touch no RAM; otherwise low address bits are forced to zero.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

`ifdef MAU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  mau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              signed_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              accept;
  logic [1:0]        req_size_n;
  logic              req_mis;
  logic [ADDR_W-1:0] req_addr_fix;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       merged_word;
  logic [31:0]       load_data;

  assign req_size_n = norm_size(req_size);
  assign req_mis    = is_misaligned(req_size_n, req_addr[1:0]);
  assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};

  // Clear the offending low address bits so a non-trapping misaligned access runs aligned.
  always_comb begin
    req_addr_fix = req_addr;
    if (req_size_n == SZ_HALF) req_addr_fix[0] = 1'b0;
    if (req_size_n == SZ_WORD) req_addr_fix[1:0] = 2'b00;
  end

  mau_lane_merge u_lane (
    .old_word_i (word_q),
    .wdata_i    (wdata_q),
    .rd_word_i  (ram_rdata),
    .lo_i       (addr_q[1:0]),
    .size_i     (size_q),
    .signed_i   (signed_q),
    .st_word_o  (merged_word),
    .ld_data_o  (load_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and RAM/handshake outputs, all decoded from the current state.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_done  = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (TrapEn && req_mis)                    state_d = RESP;
          else if (req_we && req_size_n == SZ_WORD) state_d = WR;
          else                                      state_d = RD;
        end
      end
      RD: begin
        ram_re   = 1'b1;
        ram_addr = word_addr;
        state_d  = we_q ? WR : RESP;
      end
      WR: begin
        ram_we    = 1'b1;
        ram_addr  = word_addr;
        ram_wdata = merged_word;
        state_d   = RESP;
      end
      default: begin
        rsp_done = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // Request capture on accept; RAM word and load result capture during RD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      word_q      <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q      <= req_addr_fix;
        size_q      <= req_size_n;
        we_q        <= req_we;
        signed_q    <= req_signed;
        wdata_q     <= req_wdata;
        rsp_rdata_q <= '0;
      end
      if (state_q == RD) begin
        word_q <= ram_rdata;
        if (!we_q) rsp_rdata_q <= load_data;
      end
    end
  end

  assign rsp_rdata = rsp_rdata_q;

`ifdef MAU_MISALIGN_TRAP_EN
  logic rsp_err_q;

  // Error flag is decided at accept and held until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rsp_err_q <= 1'b0;
    else if (accept) rsp_err_q <= req_mis;
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural word RAM.
// Honours MAU_MISALIGN_TRAP_EN to pick the expected misaligned behaviour.
module tb_mem_access_unit;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int dn_cnt = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_done   (rsp_done),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    if (ram_we)     mem[ram_addr[7:2]] <= ram_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  always @(negedge clk) begin
    if (ram_we)   we_cnt <= we_cnt + 1;
    if (ram_re)   re_cnt <= re_cnt + 1;
    if (rsp_done) dn_cnt <= dn_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    step();
    pl_en   = 1'b0;
  endtask

  // One request; lat counts the accept cycle as cycle 0.
  task automatic run(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] ad, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er,
                     output int nwe, output int nre);
    int we0;
    int re0;
    we0        = we_cnt;
    re0        = re_cnt;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
    lat        = 1;
    while (!rsp_done && lat < 10) begin
      step();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    step();
    nwe = we_cnt - we0;
    nre = re_cnt - re0;
    $display("txn we=%0b size=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b lat=%0d we=%0d re=%0d",
             we, sz, ad, wd, rd, er, lat, nwe, nre);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          nwe;
  int          nre;
  int          n;
  int          dn0;
  logic [4:0]  rdy_v;
  logic [4:0]  dn_v;

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = W;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    pl_en      = 1'b0;
    pl_idx     = '0;
    pl_data    = '0;

    for (int i = 0; i < 64; i++) begin
      preload(6'(i), (i == 0) ? 32'hF654_3210 :
                     (i == 4) ? 32'h8899_AABB :
                     (i == 8) ? 32'h1122_3344 : 32'h0);
    end

    chk("rst_done",  {31'b0, rsp_done},  32'd0);
    chk("rst_err",   {31'b0, rsp_err},   32'd0);
    chk("rst_rdata", rsp_rdata,          32'd0);
    chk("rst_we",    {31'b0, ram_we},    32'd0);
    chk("rst_re",    {31'b0, ram_re},    32'd0);
    chk("rst_addr",  ram_addr,           32'd0);
    chk("rst_wdata", ram_wdata,          32'd0);
    reset = 1'b1;
    step();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    // Loads from word 0x10 = 0x8899AABB.
    run(1'b0, B, 1'b1, 32'h11, 32'h0, lat, rd, er, nwe, nre);
    chk("ldb_s_data", rd, 32'hFFFF_FFAA);
    chk("ldb_s_lat",  32'(lat), 32'd2);
    chk("ldb_s_re",   32'(nre), 32'd1);
    chk("ldb_s_we",   32'(nwe), 32'd0);
    chk("ldb_s_err",  {31'b0, er}, 32'd0);
    step();
    chk("ldb_hold",   rsp_rdata, 32'hFFFF_FFAA);
    chk("done_pulse", {31'b0, rsp_done}, 32'd0);

    run(1'b0, B, 1'b0, 32'h13, 32'h0, lat, rd, er, nwe, nre);
    chk("ldb_u_data", rd, 32'h0000_0088);
    run(1'b0, H, 1'b1, 32'h12, 32'h0, lat, rd, er, nwe, nre);
    chk("ldh_s_data", rd, 32'hFFFF_8899);
    run(1'b0, H, 1'b0, 32'h10, 32'h0, lat, rd, er, nwe, nre);
    chk("ldh_u_data", rd, 32'h0000_AABB);

    // Sub-word stores (read-modify-write).
    run(1'b1, H, 1'b0, 32'h12, 32'hFFFF_1234, lat, rd, er, nwe, nre);
    chk("sth_lat",   32'(lat), 32'd3);
    chk("sth_we",    32'(nwe), 32'd1);
    chk("sth_rdata", rd, 32'd0);
    chk("sth_mem",   mem[4], 32'h1234_AABB);
    run(1'b1, B, 1'b0, 32'h10, 32'hFFFF_FF5A, lat, rd, er, nwe, nre);
    chk("stb_lat",   32'(lat), 32'd3);
    chk("stb_mem",   mem[4], 32'h1234_AA5A);

    // Word store then word load.
    run(1'b1, W, 1'b0, 32'h04, 32'hDEAD_BEEF, lat, rd, er, nwe, nre);
    chk("stw_lat", 32'(lat), 32'd2);
    chk("stw_re",  32'(nre), 32'd0);
    chk("stw_we",  32'(nwe), 32'd1);
    chk("stw_mem", mem[1], 32'hDEAD_BEEF);
    run(1'b0, W, 1'b0, 32'h04, 32'h0, lat, rd, er, nwe, nre);
    chk("ldw_data", rd, 32'hDEAD_BEEF);
    chk("ldw_lat",  32'(lat), 32'd2);
    run(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, lat, rd, er, nwe, nre);
    chk("ld11_data", rd, 32'hDEAD_BEEF);

    // Misaligned accesses.
    run(1'b0, H, 1'b1, 32'h03, 32'h0, lat, rd, er, nwe, nre);
`ifdef MAU_MISALIGN_TRAP_EN
    chk("mis_h_err",   {31'b0, er}, 32'd1);
    chk("mis_h_data",  rd, 32'd0);
    chk("mis_h_re",    32'(nre), 32'd0);
    chk("mis_h_lat",   32'(lat), 32'd1);
`else
    chk("mis_h_err",   {31'b0, er}, 32'd0);
    chk("mis_h_data",  rd, 32'hFFFF_F654);
    chk("mis_h_re",    32'(nre), 32'd1);
    chk("mis_h_lat",   32'(lat), 32'd2);
`endif
    run(1'b0, W, 1'b0, 32'h05, 32'h0, lat, rd, er, nwe, nre);
`ifdef MAU_MISALIGN_TRAP_EN
    chk("mis_w_err",  {31'b0, er}, 32'd1);
    chk("mis_w_data", rd, 32'd0);
`else
    chk("mis_w_err",  {31'b0, er}, 32'd0);
    chk("mis_w_data", rd, 32'hDEAD_BEEF);
`endif
    run(1'b1, W, 1'b0, 32'h0A, 32'h5555_AAAA, lat, rd, er, nwe, nre);
`ifdef MAU_MISALIGN_TRAP_EN
    chk("mis_st_we",  32'(nwe), 32'd0);
    chk("mis_st_mem", mem[2], 32'd0);
`else
    chk("mis_st_we",  32'(nwe), 32'd1);
    chk("mis_st_mem", mem[2], 32'h5555_AAAA);
`endif

    // Reset in RD of a byte store to 0x20 abandons it.
    nwe        = we_cnt;
    dn0        = dn_cnt;
    req_we     = 1'b1;
    req_size   = B;
    req_signed = 1'b0;
    req_addr   = 32'h20;
    req_wdata  = 32'h0000_00EE;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
    chk("arst_in_rd", {31'b0, ram_re}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_re",    {31'b0, ram_re},   32'd0);
    chk("arst_we",    {31'b0, ram_we},   32'd0);
    chk("arst_done",  {31'b0, rsp_done}, 32'd0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("arst_nowe",  32'(we_cnt - nwe), 32'd0);
    chk("arst_nodn",  32'(dn_cnt - dn0), 32'd0);
    chk("arst_mem",   mem[8], 32'h1122_3344);
    chk("arst_ready", {31'b0, req_ready}, 32'd1);
    chk("arst_rdata", rsp_rdata, 32'd0);
    $display("txn reset during RD of byte store addr=0x00000020 -> mem=0x%08h ready=%0b", mem[8], req_ready);

    // req_valid held high across a busy store.
    req_we     = 1'b1;
    req_size   = B;
    req_signed = 1'b0;
    req_addr   = 32'h24;
    req_wdata  = 32'h77;
    req_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rdy_v[c] = req_ready;
      dn_v[c]  = rsp_done;
      if (c == 1) begin
        req_addr  = 32'h25;
        req_wdata = 32'h66;
      end
      step();
    end
    req_valid = 1'b0;
    n = 0;
    while (!rsp_done && n < 10) begin
      step();
      n++;
    end
    step();
    chk("hold_ready_v", {27'b0, rdy_v}, 32'b10001);
    chk("hold_done_v",  {27'b0, dn_v},  32'b01000);
    chk("hold_2nd_lat", 32'(n), 32'd2);
    chk("hold_mem",     mem[9], 32'h0000_6677);
    $display("txn held req_valid: ready=%05b done=%05b mem=0x%08h", rdy_v, dn_v, mem[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
